// File: rtl/dp_pkg.sv
// Shared types and widths for the dot_product datapath and its loader front-end.
package dp_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned DP_N     = 8;
  localparam int unsigned DP_RES_W = WORD_W;
  localparam int unsigned DP_VEC_W = WORD_W * DP_N;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    COMPUTE = 2'd2,
    OUT     = 2'd3
  } dp_load_state_t;

endpackage

// File: rtl/dot_product_loader.sv
// Packs a stream of words into vectors A and B, holds them for the combinational
// dot_product datapath, then captures and presents the result on valid/ready.
module dot_product_loader
  import dp_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WORD_W*N-1:0]   a_vec,
  output logic [WORD_W*N-1:0]   b_vec,
  input  logic [DP_RES_W-1:0]   dp_result,
  output logic [DP_RES_W-1:0]   res_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned VEC_W = WORD_W * N;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  dp_load_state_t      r_state;
  dp_load_state_t      w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [VEC_W-1:0]    r_a_vec;
  logic [VEC_W-1:0]    w_a_vec_nxt;
  logic [VEC_W-1:0]    r_b_vec;
  logic [VEC_W-1:0]    w_b_vec_nxt;
  logic [DP_RES_W-1:0] r_res_data;
  logic [DP_RES_W-1:0] w_res_data_nxt;
  logic                r_res_valid;
  logic                w_res_valid_nxt;
  logic                w_load_state;

  // State and datapath registers; reset discards any partial load or pending result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= LOAD_A;
      r_idx       <= '0;
      r_a_vec     <= '0;
      r_b_vec     <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_a_vec     <= w_a_vec_nxt;
      r_b_vec     <= w_b_vec_nxt;
      r_res_data  <= w_res_data_nxt;
      r_res_valid <= w_res_valid_nxt;
    end
  end

  // Next-state: element writes in the load states, result capture on COMPUTE exit.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_a_vec_nxt     = r_a_vec;
    w_b_vec_nxt     = r_b_vec;
    w_res_data_nxt  = r_res_data;
    w_res_valid_nxt = r_res_valid;
    unique case (r_state)
      LOAD_A: begin
        if (in_valid) begin
          w_a_vec_nxt[WORD_W*32'(r_idx) +: WORD_W] = in_data;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = LOAD_B;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      LOAD_B: begin
        if (in_valid) begin
          w_b_vec_nxt[WORD_W*32'(r_idx) +: WORD_W] = in_data;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = COMPUTE;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      COMPUTE: begin
        w_res_data_nxt  = dp_result;
        w_res_valid_nxt = 1'b1;
        w_state_nxt     = OUT;
      end
      OUT: begin
        if (res_ready) begin
          w_res_valid_nxt = 1'b0;
          w_idx_nxt       = '0;
          w_state_nxt     = LOAD_A;
        end
      end
      default: begin
        w_state_nxt = LOAD_A;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Handshake decode from the state register only, forced low while in reset.
  always_comb begin
    w_load_state = (r_state == LOAD_A) || (r_state == LOAD_B);
    in_ready     = rst_n && w_load_state;
    busy         = rst_n && !((r_state == LOAD_A) && (r_idx == '0));
  end

  assign a_vec     = r_a_vec;
  assign b_vec     = r_b_vec;
  assign res_data  = r_res_data;
  assign res_valid = r_res_valid;

endmodule

// File: tb/tb_dot_product_loader.sv
// Directed bench for dot_product_loader with a behavioural dot_product stub.
module tb_dot_product_loader;

  localparam int unsigned NE = 8;
  localparam int unsigned W  = 32;
  localparam int unsigned VW = W * NE;

  typedef logic [NE-1:0][W-1:0] vec_t;

  typedef struct {
    vec_t        a;
    vec_t        b;
    logic [31:0] exp;
    bit          gap;
  } vec_rec_t;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] a_vec;
  logic [VW-1:0] b_vec;
  logic [W-1:0]  dp_result;
  logic [W-1:0]  res_data;
  logic          res_valid;
  logic          res_ready;
  logic          busy;

  int n_cmp;
  int n_fail;

  dot_product_loader #(.N(NE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_vec     (a_vec),
    .b_vec     (b_vec),
    .dp_result (dp_result),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the downstream combinational dot_product (modulo 2^32).
  function automatic logic [31:0] dp_model(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < NE; i++) acc = acc + a[W*i +: W] * b[W*i +: W];
    return acc;
  endfunction

  assign dp_result = dp_model(a_vec, b_vec);

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one word; optional idle gap first. Returns after the accepting edge (+1).
  task automatic push(input logic [31:0] w, input bit gap);
    bit ok;
    int idle;
    @(negedge clk);
    if (gap) begin
      idle = int'($urandom_range(0, 3));
      in_valid = 1'b0;
      in_data  = $urandom;
      for (int k = 0; k < idle; k++) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = w;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("push_accept", {255'b0, ok}, {255'b0, 1'b1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Load one A/B pair and check COMPUTE timing and the captured result.
  task automatic run_op(input vec_rec_t r, input bit hold_ready);
    res_ready = !hold_ready;
    for (int i = 0; i < 2 * NE; i++) push((i < NE) ? r.a[i] : r.b[i - NE], r.gap);
    chk("compute_in_ready", {255'b0, in_ready}, '0);
    chk("compute_res_valid", {255'b0, res_valid}, '0);
    chk("compute_busy", {255'b0, busy}, {255'b0, 1'b1});
    @(posedge clk);
    #1;
    chk("out_res_valid", {255'b0, res_valid}, {255'b0, 1'b1});
    chk("out_res_data", {224'b0, res_data}, {224'b0, r.exp});
    chk("out_a_vec", a_vec, r.a);
    chk("out_b_vec", b_vec, r.b);
    if (!hold_ready) begin
      @(posedge clk);
      #1;
      chk("post_res_valid", {255'b0, res_valid}, '0);
      chk("post_in_ready", {255'b0, in_ready}, {255'b0, 1'b1});
      chk("post_busy", {255'b0, busy}, '0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, {255'b0, in_ready}, '0);
    chk({tag, "_res_valid"}, {255'b0, res_valid}, '0);
    chk({tag, "_busy"}, {255'b0, busy}, '0);
    chk({tag, "_a_vec"}, a_vec, '0);
    chk({tag, "_b_vec"}, b_vec, '0);
    chk({tag, "_res_data"}, {224'b0, res_data}, '0);
  endtask

  vec_rec_t tbl[7];
  vec_t     va_seq;
  vec_t     vb_one;
  vec_t     vb_rev;
  vec_t     va_dbl;
  vec_t     v_10000;
  vec_t     v_ffff;

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    res_ready = 1'b0;

    for (int i = 0; i < NE; i++) begin
      va_seq[i]  = 32'(i + 1);
      vb_one[i]  = 32'd1;
      vb_rev[i]  = 32'(NE - i);
      va_dbl[i]  = 32'(2 * (i + 1));
      v_10000[i] = 32'h0001_0000;
      v_ffff[i]  = 32'hFFFF_FFFF;
    end
    tbl[0] = '{a: va_seq,  b: vb_one,  exp: 32'd36,        gap: 1'b0};
    tbl[1] = '{a: va_seq,  b: vb_rev,  exp: 32'd120,       gap: 1'b0};
    tbl[2] = '{a: va_dbl,  b: vb_one,  exp: 32'd72,        gap: 1'b0};
    tbl[3] = '{a: v_10000, b: v_10000, exp: 32'h0000_0000, gap: 1'b0};
    tbl[4] = '{a: v_ffff,  b: vb_one,  exp: 32'hFFFF_FFF8, gap: 1'b0};
    tbl[5] = '{a: va_seq,  b: vb_one,  exp: 32'd36,        gap: 1'b1};
    tbl[6] = '{a: va_seq,  b: vb_rev,  exp: 32'd120,       gap: 1'b1};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_in_ready", {255'b0, in_ready}, {255'b0, 1'b1});
    chk("first_busy", {255'b0, busy}, '0);

    // Table-driven back-to-back operations (res_ready held high ahead of res_valid)
    for (int t = 0; t < 7; t++) run_op(tbl[t], 1'b0);

    // Output backpressure with traffic on the input
    run_op(tbl[1], 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = $urandom;
      @(posedge clk);
      #1;
      chk("bp_in_ready", {255'b0, in_ready}, '0);
      chk("bp_res_valid", {255'b0, res_valid}, {255'b0, 1'b1});
      chk("bp_res_data", {224'b0, res_data}, 256'd120);
      chk("bp_a_vec", a_vec, va_seq);
      chk("bp_b_vec", b_vec, vb_rev);
    end
    @(negedge clk);
    in_data   = 32'hDEAD_BEEF;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", {255'b0, res_valid}, '0);
    chk("bp_release_ready", {255'b0, in_ready}, {255'b0, 1'b1});
    chk("bp_no_latch_a", a_vec, va_seq);
    in_valid = 1'b0;
    run_op(tbl[2], 1'b0);

    // Reset in the middle of an A load
    for (int i = 0; i < 5; i++) push(32'(i + 100), 1'b0);
    chk("midload_busy", {255'b0, busy}, {255'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", {255'b0, in_ready}, {255'b0, 1'b1});
    run_op(tbl[0], 1'b0);

    // Reset while a result is pending in OUT
    run_op(tbl[1], 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("outrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(tbl[4], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
